// File: rtl/dm_lsu_ctrl.sv
// Load/store initiator: turns one CPU memory request at a time into SRAM port
// activity and returns aligned, extended load data or an access error.
module dm_lsu_ctrl #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              DM_WEB,
  output logic [31:0]       DM_BWEB,
  output logic [ADDR_W-1:0] DM_A,
  output logic [31:0]       DM_DI,
  input  logic [31:0]       DM_DO
);

  typedef enum logic [1:0] {IDLE, RD, RESP} state_t;

  state_t      state_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        is_half;
  logic        is_word;
  logic        f3_ok;
  logic        req_err;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_d;
  logic        unused_addr;

  assign unused_addr = ^{req_addr[31:ADDR_W+2]};

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign accept     = req_valid && (state_q == IDLE);

  // funct3[1:0] encodes access size for both loads and stores
  assign is_half = (req_funct3[1:0] == 2'b01);
  assign is_word = (req_funct3[1:0] == 2'b10);

  always_comb begin
    f3_ok = 1'b0;
    if (req_we) begin
      f3_ok = (req_funct3 == 3'd0) || (req_funct3 == 3'd1) || (req_funct3 == 3'd2);
    end else begin
      f3_ok = (req_funct3 == 3'd0) || (req_funct3 == 3'd1) || (req_funct3 == 3'd2) ||
              (req_funct3 == 3'd4) || (req_funct3 == 3'd5);
    end
  end

  assign req_err = !f3_ok || (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));

  // SRAM port is only driven while a legal request is being accepted
  always_comb begin
    DM_WEB  = 1'b1;
    DM_BWEB = 32'hFFFF_FFFF;
    DM_A    = '0;
    DM_DI   = 32'h0;
    if (accept && !req_err) begin
      DM_A = req_addr[ADDR_W+1:2];
      if (req_we) begin
        DM_WEB = 1'b0;
        case (req_funct3[1:0])
          2'b00: begin
            DM_DI   = {4{req_wdata[7:0]}};
            DM_BWEB = ~(32'h0000_00FF << {req_addr[1:0], 3'b000});
          end
          2'b01: begin
            DM_DI   = {2{req_wdata[15:0]}};
            DM_BWEB = ~(32'h0000_FFFF << {req_addr[1], 4'b0000});
          end
          default: begin
            DM_DI   = req_wdata;
            DM_BWEB = 32'h0;
          end
        endcase
      end
    end
  end

  assign byte_sel = DM_DO[{off_q, 3'b000} +: 8];
  assign half_sel = off_q[1] ? DM_DO[31:16] : DM_DO[15:0];

  always_comb begin
    load_d = DM_DO;
    case (f3_q)
      3'd0:    load_d = {{24{byte_sel[7]}}, byte_sel};
      3'd1:    load_d = {{16{half_sel[15]}}, half_sel};
      3'd4:    load_d = {24'h0, byte_sel};
      3'd5:    load_d = {16'h0, half_sel};
      default: load_d = DM_DO;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      off_q   <= 2'b00;
      f3_q    <= 3'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            off_q <= req_addr[1:0];
            f3_q  <= req_funct3;
            if (req_err || req_we) begin
              rdata_q <= 32'h0;
              err_q   <= req_err;
              state_q <= RESP;
            end else begin
              state_q <= RD;
            end
          end
        end
        RD: begin
          rdata_q <= load_d;
          err_q   <= 1'b0;
          state_q <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
